// File: rtl/xs3_to_bcd_seq.sv
// Sequential excess-3 to BCD decoder: accepts a packed excess-3 word, decodes
// one digit per clock (LSD first) and presents the BCD word with per-digit error flags.
module xs3_to_bcd_seq #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   xs3_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [DIGITS-1:0]     err_mask,
  output logic                  err
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t              state_reg, state_next;
  logic [IDX_W-1:0]    idx_reg, idx_next;
  logic [4*DIGITS-1:0] xs3_reg, xs3_next;
  logic [4*DIGITS-1:0] bcd_reg, bcd_next;
  logic [DIGITS-1:0]   mask_reg, mask_next;
  logic                in_ready_reg, in_ready_next;
  logic                out_valid_reg, out_valid_next;
  logic                err_reg, err_next;

  logic [3:0]          dec_digit [DIGITS];
  logic [DIGITS-1:0]   dec_bad;

  // Every captured digit is decoded in parallel; the FSM only picks digit idx.
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_dec
      logic [3:0] code;
      assign code          = xs3_reg[4*gi +: 4];
      assign dec_bad[gi]   = (code < 4'd3) || (code > 4'd12);
      assign dec_digit[gi] = dec_bad[gi] ? 4'd0 : (code - 4'd3);
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    xs3_next   = xs3_reg;
    bcd_next   = bcd_reg;
    mask_next  = mask_reg;
    case (state_reg)
      IDLE: begin
        if (in_valid && in_ready_reg) begin
          xs3_next   = xs3_in;
          bcd_next   = '0;
          mask_next  = '0;
          idx_next   = '0;
          state_next = CONV;
        end
      end
      CONV: begin
        for (int i = 0; i < DIGITS; i++) begin
          if (idx_reg == IDX_W'(i)) begin
            bcd_next[4*i +: 4] = dec_digit[i];
            mask_next[i]       = dec_bad[i];
          end
        end
        if (idx_reg == LAST_IDX) begin
          idx_next   = '0;
          state_next = DONE;
        end else begin
          idx_next = idx_reg + 1'b1;
        end
      end
      DONE: begin
        if (out_valid_reg && out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    // Handshake flags are derived from the next state so they stay registered.
    in_ready_next  = (state_next == IDLE);
    out_valid_next = (state_next == DONE);
    err_next       = |mask_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      idx_reg       <= '0;
      xs3_reg       <= '0;
      bcd_reg       <= '0;
      mask_reg      <= '0;
      in_ready_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      idx_reg       <= idx_next;
      xs3_reg       <= xs3_next;
      bcd_reg       <= bcd_next;
      mask_reg      <= mask_next;
      in_ready_reg  <= in_ready_next;
      out_valid_reg <= out_valid_next;
      err_reg       <= err_next;
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign bcd_out   = bcd_reg;
  assign err_mask  = mask_reg;
  assign err       = err_reg;

endmodule

// File: tb/tb_xs3_to_bcd_seq.sv
// Scoreboard bench for xs3_to_bcd_seq: a 4-digit instance for word traffic,
// backpressure and reset abort, and a 1-digit instance for the full code sweep.
module tb_xs3_to_bcd_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic        in_valid = 1'b0, out_ready = 1'b0;
  logic [15:0] xs3_in = '0;
  logic        in_ready, out_valid, err;
  logic [15:0] bcd_out;
  logic [3:0]  err_mask;

  logic        in_valid_1 = 1'b0, out_ready_1 = 1'b0;
  logic [3:0]  xs3_in_1 = '0;
  logic        in_ready_1, out_valid_1, err_1;
  logic [3:0]  bcd_out_1;
  logic [0:0]  err_mask_1;

  xs3_to_bcd_seq #(.DIGITS(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .xs3_in(xs3_in), .out_valid(out_valid), .out_ready(out_ready),
    .bcd_out(bcd_out), .err_mask(err_mask), .err(err)
  );

  xs3_to_bcd_seq #(.DIGITS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_1), .in_ready(in_ready_1),
    .xs3_in(xs3_in_1), .out_valid(out_valid_1), .out_ready(out_ready_1),
    .bcd_out(bcd_out_1), .err_mask(err_mask_1), .err(err_1)
  );

  typedef struct packed {
    logic [15:0] bcd;
    logic [3:0]  mask;
  } exp_t;

  exp_t sb[$];
  exp_t sb1[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference decode of one word, digit by digit.
  function automatic exp_t model(input logic [15:0] w);
    exp_t e;
    logic [3:0] c;
    e = '0;
    for (int d = 0; d < 4; d++) begin
      c = w[4*d +: 4];
      if (c >= 4'd3 && c <= 4'd12) e.bcd[4*d +: 4] = c - 4'd3;
      else e.mask[d] = 1'b1;
    end
    return e;
  endfunction

  // One word through the 4-digit instance; optionally drives a pending word
  // on in_valid while the result is held back.
  task automatic tx(input logic [15:0] w, input logic [15:0] ebcd, input logic [3:0] emask,
                    input int hold, input logic use_pend, input logic [15:0] pend);
    int n;
    exp_t e, got;
    n = 0;
    while (!in_ready && n < 40) begin @(negedge clk); n++; end
    chk("accept_ready", in_ready, 1);
    in_valid = 1'b1;
    xs3_in   = w;
    sb.push_back('{bcd: ebcd, mask: emask});
    @(negedge clk);
    in_valid = 1'b0;
    chk("conv_in_ready_low", in_ready, 0);
    n = 0;
    while (!out_valid && n < 40) begin @(negedge clk); n++; end
    chk("latency", n, 4);
    chk("no_overlap", in_ready, 0);
    got = {bcd_out, err_mask};
    if (use_pend) begin
      in_valid = 1'b1;
      xs3_in   = pend;
    end
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      chk("hold_stable", got, {bcd_out, err_mask});
      chk("hold_handshake", {in_ready, out_valid}, 2'b01);
    end
    chk("sb_nonempty", sb.size() != 0, 1);
    e = sb.pop_front();
    out_ready = 1'b1;
    chk("bcd", bcd_out, e.bcd);
    chk("err_mask", err_mask, e.mask);
    chk("err", err, |e.mask);
    $display("word xs3=%h bcd=%h mask=%b err=%b", w, bcd_out, err_mask, err);
    @(negedge clk);
    out_ready = 1'b0;
    chk("post_valid_low", out_valid, 0);
    chk("post_ready_high", in_ready, 1);
    chk("mask_kept", err_mask, e.mask);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t e;
    logic [15:0] w;
    logic seen;
    logic [3:0] c;
    logic legal;

    #2 rst_n = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_bcd", bcd_out, 0);
    chk("rst_mask_err", {err_mask, err}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("first_in_ready", in_ready, 1);

    tx(16'h4567, 16'h1234, 4'b0000, 0, 1'b0, 16'h0);
    tx(16'h3333, 16'h0000, 4'b0000, 0, 1'b0, 16'h0);
    tx(16'hCCCC, 16'h9999, 4'b0000, 0, 1'b0, 16'h0);
    tx(16'h4F67, 16'h1034, 4'b0100, 0, 1'b0, 16'h0);
    tx(16'h0000, 16'h0000, 4'b1111, 0, 1'b0, 16'h0);
    tx(16'h8976, 16'h5643, 4'b0000, 5, 1'b1, 16'h3C3C);
    tx(16'h3C3C, 16'h0909, 4'b0000, 0, 1'b0, 16'h0);
    for (int r = 0; r < 4; r++) begin
      w = 16'($urandom);
      e = model(w);
      tx(w, e.bcd, e.mask, r, 1'b0, 16'h0);
    end

    // Reset two cycles after accept aborts the word.
    in_valid = 1'b1;
    xs3_in   = 16'h5678;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_in_ready", in_ready, 0);
    chk("abort_outputs", {out_valid, bcd_out, err_mask, err}, 0);
    @(negedge clk);
    chk("abort_hold", {in_ready, out_valid, bcd_out, err_mask, err}, 0);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("abort_no_valid", seen, 0);
    chk("abort_ready_again", in_ready, 1);
    $display("reset abort checked out_valid_seen=%b", seen);

    // Single-digit sweep of every code.
    for (int k = 0; k < 16; k++) begin
      c = 4'(k);
      legal = (k >= 3) && (k <= 12);
      chk("d1_ready", in_ready_1, 1);
      in_valid_1 = 1'b1;
      xs3_in_1   = c;
      sb1.push_back('{bcd: legal ? 16'(k - 3) : 16'h0, mask: legal ? 4'b0 : 4'b1});
      @(negedge clk);
      in_valid_1 = 1'b0;
      chk("d1_conv", out_valid_1, 0);
      @(negedge clk);
      chk("d1_latency", out_valid_1, 1);
      e = sb1.pop_front();
      chk("d1_bcd", bcd_out_1, e.bcd[3:0]);
      chk("d1_err", {err_mask_1, err_1}, {e.mask[0], e.mask[0]});
      $display("d1 code=%h bcd=%h err=%b", c, bcd_out_1, err_1);
      out_ready_1 = 1'b1;
      @(negedge clk);
      out_ready_1 = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
